ysyx_23060096_alu_arb: RTL and testbench

YSYX_23060096_ALU_ARB -- requirements
Module: ysyx_23060096_alu_arb

---
 rtl/ysyx_23060096_alu_arb.sv | 131 +++++++++++++
 tb/tb_ysyx_23060096_alu_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060096_alu_arb.sv
// Two-requester arbiter in front of a single shared ALU.
// Each accepted request yields one registered response.
module ysyx_23060096_alu (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      3'b000: y = a + b;
      3'b001: y = a - b;
      3'b010: y = a ^ b;
      3'b011: y = a & b;
      3'b100: y = a | b;
      3'b101: y = a << b[4:0];
      3'b110: y = a >> b[4:0];
      3'b111: y = {31'b0, a < b};
    endcase
  end

endmodule

module ysyx_23060096_alu_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        id_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic [31:0] alu_y;
  logic        gnt1;
  logic        acc0;
  logic        acc1;

  ysyx_23060096_alu u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  // req1 wins a tie only when the previous grant went to req0
  always_comb begin
    if (RR_EN)
      gnt1 = req1_valid &&
             (!req0_valid || !last_grant);
    else
      gnt1 = req1_valid && !req0_valid;
    acc0 = (state == IDLE) &&
           req0_valid && !gnt1;
    acc1 = (state == IDLE) && gnt1;
  end

  assign req0_ready = acc0;
  assign req1_ready = acc1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      ops_done   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc0 || acc1) begin
            a_q        <= acc1 ? req1_a  : req0_a;
            b_q        <= acc1 ? req1_b  : req0_b;
            op_q       <= acc1 ? req1_op : req0_op;
            id_q       <= acc1;
            last_grant <= acc1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_y;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_alu_arb.sv
// Bench for ysyx_23060096_alu_arb: RR and fixed-priority
// instances share stimulus; a scoreboard tracks responses.
module tb_ysyx_23060096_alu_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, rr;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  o0, o1;
  logic        rd0 [2];
  logic        rd1 [2];
  logic        rv  [2];
  logic        rid [2];
  logic        bz  [2];
  logic [31:0] rdat [2];
  logic [15:0] done [2];

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  exp_t        sbq [2][$];
  logic        log_id [2][$];
  logic [31:0] log_dat [2][$];
  vec_t        vt [12];
  int          n_chk = 0;
  int          n_fail = 0;
  int          hs [2];
  int          acc1_cnt [2];
  bit          logging = 1'b0;

  always #5 clk = ~clk;

  ysyx_23060096_alu_arb #(.RR_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rd0[0]),
    .req0_a(a0), .req0_b(b0), .req0_op(o0),
    .req1_valid(v1), .req1_ready(rd1[0]),
    .req1_a(a1), .req1_b(b1), .req1_op(o1),
    .rsp_valid(rv[0]), .rsp_ready(rr),
    .rsp_id(rid[0]), .rsp_data(rdat[0]),
    .busy(bz[0]), .ops_done(done[0])
  );

  ysyx_23060096_alu_arb #(.RR_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rd0[1]),
    .req0_a(a0), .req0_b(b0), .req0_op(o0),
    .req1_valid(v1), .req1_ready(rd1[1]),
    .req1_a(a1), .req1_b(b1), .req1_op(o1),
    .rsp_valid(rv[1]), .rsp_ready(rr),
    .rsp_id(rid[1]), .rsp_data(rdat[1]),
    .busy(bz[1]), .ops_done(done[1])
  );

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] model(
    logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a ^ b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return {31'b0, a < b};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq[0].delete();
      sbq[1].delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        chk("ready_excl", {31'b0, rd0[k] & rd1[k]}, 0);
        if (v0 && rd0[k])
          sbq[k].push_back('{1'b0, model(o0, a0, b0)});
        if (v1 && rd1[k]) begin
          sbq[k].push_back('{1'b1, model(o1, a1, b1)});
          acc1_cnt[k]++;
        end
        if (rv[k] && rr) begin
          hs[k]++;
          if (sbq[k].size() == 0) begin
            chk("sb_unexpected_rsp", 1, 0);
          end else begin
            e = sbq[k].pop_front();
            chk("sb_id", {31'b0, rid[k]}, {31'b0, e.id});
            chk("sb_data", rdat[k], e.data);
          end
          if (logging) begin
            log_id[k].push_back(rid[k]);
            log_dat[k].push_back(rdat[k]);
          end
        end
      end
    end
  end

  task automatic issue(input bit id,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [2:0]  op);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    if (id) begin
      v1 = 1'b1; a1 = a; b1 = b; o1 = op;
    end else begin
      v0 = 1'b1; a0 = a; b0 = b; o0 = op;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (id ? rd1[0] : rd0[0]) ok = 1'b1;
    end
    chk("issue_accept", {31'b0, ok}, 1);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] d,
                          output logic id);
    bit ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (rv[0]) ok = 1'b1;
    end
    chk("rsp_timeout", {31'b0, ok}, 1);
    d  = rdat[0];
    id = rid[0];
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        id;
    logic [15:0] d0;
    bit          seen;
    logic        exp_id0 [4];
    logic [31:0] exp_dat0 [4];

    vt[0]  = '{3'd0, 32'd5,        32'd3,        32'd8};
    vt[1]  = '{3'd1, 32'd10,       32'd3,        32'd7};
    vt[2]  = '{3'd1, 32'd0,        32'd1,        32'hFFFF_FFFF};
    vt[3]  = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vt[4]  = '{3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vt[5]  = '{3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
    vt[6]  = '{3'd5, 32'd1,        32'd31,       32'h8000_0000};
    vt[7]  = '{3'd5, 32'd1,        32'd33,       32'd2};
    vt[8]  = '{3'd6, 32'h8000_0000, 32'd4,        32'h0800_0000};
    vt[9]  = '{3'd7, 32'd1,        32'd2,        32'd1};
    vt[10] = '{3'd7, 32'hFFFF_FFFF, 32'd1,        32'd0};
    vt[11] = '{3'd0, 32'hFFFF_FFFF, 32'd1,        32'd0};
    exp_id0  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_dat0 = '{32'd8, 32'd7, 32'd8, 32'd7};

    rst_n = 1'b0; rr = 1'b0;
    v0 = 1'b0; a0 = '0; b0 = '0; o0 = '0;
    v1 = 1'b0; a1 = '0; b1 = '0; o1 = '0;
    hs = '{0, 0};
    acc1_cnt = '{0, 0};
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rsp_valid", {31'b0, rv[k]}, 0);
      chk("rst_busy", {31'b0, bz[k]}, 0);
      chk("rst_ops_done", {16'b0, done[k]}, 0);
      chk("rst_rsp_data", rdat[k], 0);
      chk("rst_rsp_id", {31'b0, rid[k]}, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single request, response held until consumer is ready
    issue(1'b0, 32'd5, 32'd3, 3'd0);
    chk("lat_exec_valid", {31'b0, rv[0]}, 0);
    chk("lat_exec_busy", {31'b0, bz[0]}, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("single_valid", {31'b0, rv[k]}, 1);
      chk("single_data", rdat[k], 8);
      chk("single_id", {31'b0, rid[k]}, 0);
      chk("single_cnt_pre", {16'b0, done[k]}, 0);
    end
    rr = 1'b1;
    @(posedge clk);
    #1;
    chk("single_valid_drop", {31'b0, rv[0]}, 0);
    chk("single_cnt", {16'b0, done[0]}, 1);
    chk("single_idle", {31'b0, bz[0]}, 0);

    for (int i = 0; i < 12; i++) begin
      issue(i[0], vt[i].a, vt[i].b, vt[i].op);
      wait_rsp(d, id);
      chk("vec_data", d, vt[i].exp);
      chk("vec_id", {31'b0, id}, {31'b0, i[0]});
      @(posedge clk);
      #1;
    end
    chk("vec_cnt", {16'b0, done[0]}, 13);

    // reset while an operation is in EXEC
    issue(1'b0, 32'd7, 32'd7, 3'd0);
    #2;
    chk("pre_rst_busy", {31'b0, bz[0]}, 1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_rsp_valid", {31'b0, rv[k]}, 0);
      chk("arst_busy", {31'b0, bz[k]}, 0);
      chk("arst_ops_done", {16'b0, done[k]}, 0);
      chk("arst_rsp_data", rdat[k], 0);
    end
    repeat (2) @(posedge clk);
    #1;
    acc1_cnt = '{0, 0};
    logging = 1'b1;
    rr = 1'b1;
    v0 = 1'b1; a0 = 32'd5;  b0 = 32'd3; o0 = 3'd0;
    v1 = 1'b1; a1 = 32'd10; b1 = 32'd3; o1 = 3'd1;
    rst_n = 1'b1;
    #1;
    chk("first_accept_rr", {31'b0, rd0[0]}, 1);
    chk("first_accept_fp", {31'b0, rd0[1]}, 1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (log_id[0].size() >= 4) break;
    end
    v0 = 1'b0;
    v1 = 1'b0;
    logging = 1'b0;
    chk("rr_count", log_id[0].size(), 4);
    chk("fp_count", log_id[1].size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_id[0].size()) begin
        chk("rr_id_seq", {31'b0, log_id[0][i]},
            {31'b0, exp_id0[i]});
        chk("rr_data_seq", log_dat[0][i], exp_dat0[i]);
      end
      if (i < log_id[1].size()) begin
        chk("fp_id_seq", {31'b0, log_id[1][i]}, 0);
        chk("fp_data_seq", log_dat[1][i], 8);
      end
    end
    chk("fp_req1_never", acc1_cnt[1], 0);
    repeat (3) @(posedge clk);
    #1;

    // stall in RESP with both requesters pushing
    rr = 1'b0;
    issue(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd3);
    @(posedge clk);
    #1;
    d0 = done[0];
    v0 = 1'b1; a0 = 32'h1234_5678; o0 = 3'd2;
    v1 = 1'b1; a1 = 32'd99;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("hold_valid", {31'b0, rv[k]}, 1);
        chk("hold_data", rdat[k], 32'hF000_F000);
        chk("hold_id", {31'b0, rid[k]}, 1);
        chk("hold_rdy0", {31'b0, rd0[k]}, 0);
        chk("hold_rdy1", {31'b0, rd1[k]}, 0);
        chk("hold_busy", {31'b0, bz[k]}, 1);
        chk("hold_cnt", {16'b0, done[k]}, {16'b0, d0});
      end
      a0 = a0 + 32'd1;
    end
    @(posedge clk);
    #1;
    rr = 1'b1;
    @(negedge clk);
    chk("exit_rdy0", {31'b0, rd0[0]}, 0);
    chk("exit_rdy1", {31'b0, rd1[0]}, 0);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    chk("exit_valid", {31'b0, rv[0]}, 0);
    chk("exit_cnt", {16'b0, done[0]},
        {16'b0, d0 + 16'd1});
    repeat (2) @(posedge clk);
    #1;

    // ops_done wrap after 65536 handshakes
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    hs = '{0, 0};
    seen = 1'b0;
    rr = 1'b1;
    v0 = 1'b1; a0 = 32'd1; b0 = 32'd2; o0 = 3'd0;
    for (int i = 0; i < 65536 * 3 + 50; i++) begin
      @(posedge clk);
      #1;
      if (hs[0] == 65535 && !seen) begin
        seen = 1'b1;
        chk("wrap_max", {16'b0, done[0]}, 32'h0000_FFFF);
      end
      if (hs[0] >= 65536) break;
    end
    v0 = 1'b0;
    chk("wrap_hs", hs[0], 65536);
    chk("wrap_zero_rr", {16'b0, done[0]}, 0);
    chk("wrap_zero_fp", {16'b0, done[1]}, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drain_rr", sbq[0].size(), 0);
    chk("sb_drain_fp", sbq[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
